// File: rtl/fdiv_if.sv
// Operand/result bundle for the fdiv divider: the issue side drives a/b,
// and the divider returns s with a one-cycle valid strobe.
interface fdiv_if;
  logic        valid_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid_out;
  logic [31:0] s;
  logic        busy;

  modport master (output valid_in, a, b, input valid_out, s, busy);
  modport slave  (input valid_in, a, b, output valid_out, s, busy);
endinterface

// File: rtl/fdiv.sv
// fdiv: pipelined single-precision divider, s = a * finv(b), fixed 5-cycle latency.
// Also holds finv, the truncating 3-cycle reciprocal unit (no reset, no handshake).

module finv (
  input  logic        clk,
  input  logic [31:0] x,
  output logic [31:0] r
);
  logic [24:0]       quo;
  logic [22:0]       man_p0, man_p1;
  logic [7:0]        exp_p0;
  logic              inc_p0;
  logic              sign_p0, sign_p1;
  logic signed [9:0] exp_p1;

  // 2^47 / {1,m} lies in (2^23, 2^24]; only m=0 reaches 2^24 and needs the extra exponent step
  assign quo = 25'(48'h8000_0000_0000 / {24'd0, 1'b1, x[22:0]});

  always_ff @(posedge clk) begin
    man_p0  <= quo[24] ? quo[23:1] : quo[22:0];
    inc_p0  <= quo[24];
    exp_p0  <= x[30:23];
    sign_p0 <= x[31];
    // stage 1: reciprocal exponent
    man_p1  <= man_p0;
    sign_p1 <= sign_p0;
    exp_p1  <= 10'sd253 - $signed({2'b00, exp_p0}) + $signed({9'd0, inc_p0});
    // stage 2: pack, underflow flushes to zero
    r       <= (exp_p1 <= 10'sd0) ? {sign_p1, 31'd0} : {sign_p1, exp_p1[7:0], man_p1};
  end
endmodule

module fdiv #(
  parameter logic [31:0] QNAN = 32'h7FC0_0000,
  parameter int          LAT  = 5
) (
  input logic   clk,
  input logic   rst_n,
  fdiv_if.slave io
);
  typedef enum logic [1:0] {SP_NONE, SP_QNAN, SP_INF, SP_ZERO} spc_e;

  logic [31:0]       r;
  logic              r_sign_unused;
  logic              vld_p0, vld_p1, vld_p2, vld_p3;
  logic [30:0]       a_p0, a_p1, a_p2;
  logic              sign_p0, sign_p1, sign_p2, sign_p3;
  spc_e              spc_in, spc_p0, spc_p1, spc_p2, spc_p3;
  logic [24:0]       prod_p3;
  logic signed [9:0] esum_p3;
  logic              a_zero, b_zero, a_inf, b_inf;

  // prod holds P[47:23]; the exponent is rebased on P's leading bit, then saturated
  function automatic logic [31:0] pack_result(input logic [24:0] prod,
                                              input logic signed [9:0] esum,
                                              input logic sign, input spc_e spc);
    logic [22:0]       man;
    logic signed [9:0] e;
    if (prod[24]) begin
      man = prod[23:1];
      e   = esum - 10'sd126;
    end else begin
      man = prod[22:0];
      e   = esum - 10'sd127;
    end
    case (spc)
      SP_QNAN: return QNAN;
      SP_INF:  return {sign, 8'hFF, 23'd0};
      SP_ZERO: return {sign, 31'd0};
      default: ;
    endcase
    if (e <= 10'sd0)   return {sign, 31'd0};
    if (e >= 10'sd255) return {sign, 8'hFF, 23'd0};
    return {sign, e[7:0], man};
  endfunction

  assign a_zero = (io.a[30:23] == 8'd0);
  assign b_zero = (io.b[30:23] == 8'd0);
  assign a_inf  = (io.a[30:23] == 8'hFF);
  assign b_inf  = (io.b[30:23] == 8'hFF);

  always_comb begin
    spc_in = SP_NONE;
    if ((a_zero && b_zero) || (a_inf && b_inf)) spc_in = SP_QNAN;
    else if (b_zero)                            spc_in = SP_INF;
    else if (a_inf)                             spc_in = SP_INF;
    else if (a_zero)                            spc_in = SP_ZERO;
    else if (b_inf)                             spc_in = SP_ZERO;
  end

  finv u_finv (
    .clk (clk),
    .x   (io.b),
    .r   (r)
  );

  // the reciprocal's sign is not trusted; the quotient sign comes from the raw inputs
  assign r_sign_unused = r[31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      vld_p3       <= 1'b0;
      io.valid_out <= 1'b0;
      io.s         <= 32'd0;
    end else begin
      vld_p0       <= io.valid_in;
      vld_p1       <= vld_p0;
      vld_p2       <= vld_p1;
      vld_p3       <= vld_p2;
      io.valid_out <= vld_p3;
      if (vld_p3) io.s <= pack_result(prod_p3, esum_p3, sign_p3, spc_p3);
    end
  end

  always_ff @(posedge clk) begin
    a_p0    <= io.a[30:0];
    sign_p0 <= io.a[31] ^ io.b[31];
    spc_p0  <= spc_in;
    // stages 1-2: side band rides alongside finv
    a_p1    <= a_p0;
    sign_p1 <= sign_p0;
    spc_p1  <= spc_p0;
    a_p2    <= a_p1;
    sign_p2 <= sign_p1;
    spc_p2  <= spc_p1;
    // stage 3 (M1): mantissa product with hidden bits, exponent sum
    prod_p3 <= 25'((48'({1'b1, a_p2[22:0]}) * 48'({1'b1, r[22:0]})) >> 23);
    esum_p3 <= $signed({2'b00, a_p2[30:23]}) + $signed({2'b00, r[30:23]});
    sign_p3 <= sign_p2;
    spc_p3  <= spc_p2;
  end

  assign io.busy = vld_p0 | vld_p1 | vld_p2 | vld_p3 | io.valid_out;

  valid_from_input: assert property (@(posedge clk) disable iff (!rst_n)
    io.valid_out |-> $past(io.valid_in, LAT));
endmodule

// File: tb/tb_fdiv.sv
// Scoreboard bench for fdiv: directed cases, a mid-flight reset and random normals
// checked against an arithmetic model of a * reciprocal(b).
module tb_fdiv;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  fdiv_if bus ();

  fdiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] want;
    int          due;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sbq[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] last_s      = 32'd0;

  logic [31:0] sp_a [10] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h00000000, 32'h7F800000,
                             32'h40000000, 32'h00800000, 32'h7F000000, 32'h7F800000, 32'h3F800000};
  logic [31:0] sp_b [10] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h40400000, 32'h40000000,
                             32'h7F800000, 32'h7F000000, 32'h00800000, 32'hFF800000, 32'h3F800000};
  logic [31:0] sp_s [10] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000000, 32'h7F800000,
                             32'h00000000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h3F800000};
  logic [31:0] bb_a [8]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] bb_s [8]  = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000,
                             32'h40200000, 32'h40400000, 32'h40600000, 32'h40800000};

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // 1/b as the largest float not above the exact reciprocal; tiny results flush to zero
  function automatic logic [31:0] finv_model(logic [31:0] b);
    longint q;
    int     e;
    q = (longint'(1) <<< 47) / longint'({1'b1, b[22:0]});
    e = 253 - int'(b[30:23]);
    while (q >= (longint'(1) <<< 24)) begin
      q = q >>> 1;
      e++;
    end
    if (e <= 0) return {b[31], 31'd0};
    return {b[31], e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] div_model(logic [31:0] a, logic [31:0] b);
    int          ea, eb, er, e;
    logic        sg;
    logic [31:0] r;
    longint      p;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sg = a[31] ^ b[31];
    if ((ea == 0 && eb == 0) || (ea == 255 && eb == 255)) return 32'h7FC00000;
    if (eb == 0)   return {sg, 8'hFF, 23'd0};
    if (ea == 255) return {sg, 8'hFF, 23'd0};
    if (ea == 0)   return {sg, 31'd0};
    if (eb == 255) return {sg, 31'd0};
    r  = finv_model(b);
    er = int'(r[30:23]);
    // value = p * 2^(ea+er-300); renormalise p into [2^23, 2^24) by truncating shifts
    p  = longint'({1'b1, a[22:0]}) * longint'({1'b1, r[22:0]});
    e  = ea + er - 150;
    while (p >= (longint'(1) <<< 24)) begin
      p = p >>> 1;
      e++;
    end
    if (e <= 0)   return {sg, 31'd0};
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    return {sg, e[7:0], p[22:0]};
  endfunction

  function automatic logic [31:0] rnd_normal();
    logic [7:0] e;
    e = 8'($urandom_range(254, 1));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
    bus.valid_in = 1'b1;
    bus.a        = a;
    bus.b        = b;
    sbq.push_back('{want, cyc + 5, a, b});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // monitor: pops the scoreboard whenever a result is presented
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.valid_out) begin
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL stale_valid_out: got s=%h with no op pending, expected valid_out=0", bus.s);
          end else begin
            e = sbq.pop_front();
            check($sformatf("quotient a=%h b=%h", e.a, e.b), bus.s, e.want);
            vectors++;
            if (cyc != e.due) begin
              miscompares++;
              $display("FAIL latency a=%h b=%h: got cycle %0d, expected cycle %0d", e.a, e.b, cyc, e.due);
            end
          end
          last_s = bus.s;
        end else begin
          check("s_hold", bus.s, last_s);
        end
      end
    end
  end

  initial begin
    logic [31:0] ta, tb;
    bus.valid_in = 1'b0;
    bus.a        = 32'd0;
    bus.b        = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_s", bus.s, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // single pulse, busy must cover exactly the five pipeline cycles
    issue(32'h40C00000, 32'h40000000, 32'h40400000);
    bus.valid_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("busy_cycle%0d", k), {31'd0, bus.busy}, (k <= 5) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    issue(32'h3F800000, 32'h3F800000, 32'h3F800000);
    issue(32'hBF800000, 32'h40800000, 32'hBE800000);
    idle(6);

    for (int i = 0; i < 10; i++) issue(sp_a[i], sp_b[i], sp_s[i]);
    idle(6);

    for (int i = 0; i < 8; i++) issue(bb_a[i], 32'h40000000, bb_s[i]);
    idle(8);

    // three ops in flight, then a one-cycle reset drops them all
    for (int i = 0; i < 3; i++) begin
      ta = rnd_normal();
      tb = rnd_normal();
      issue(ta, tb, div_model(ta, tb));
    end
    idle(1);
    #2;
    rst_n = 1'b0;
    sbq.delete();
    last_s = 32'd0;
    #1;
    check("midreset_valid_out", {31'd0, bus.valid_out}, 32'd0);
    check("midreset_busy", {31'd0, bus.busy}, 32'd0);
    check("midreset_s", bus.s, 32'd0);
    bus.valid_in = 1'b1;
    bus.a        = 32'h40C00000;
    bus.b        = 32'h40000000;
    @(negedge clk);
    bus.valid_in = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h41000000, 32'h40000000, 32'h40800000);
    idle(8);

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(4, 0) == 0) idle(1);
      else begin
        ta = rnd_normal();
        tb = rnd_normal();
        issue(ta, tb, div_model(ta, tb));
      end
    end
    idle(1);

    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(negedge clk);
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL timeout a=%h b=%h: got no valid_out, expected s=%h", e.a, e.b, e.want);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
